// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : light_pkg
//  Description : Shared constants for the light input conditioner: default
//                debounce length, bit positions of each command inside the
//                5-bit command vector, and the debounce counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package light_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Bit positions inside the packed command vector.
    localparam int CMD_W = 5;
    localparam int LEFT  = 0;
    localparam int RIGHT = 1;
    localparam int BRAKE = 2;
    localparam int FOG   = 3;
    localparam int ALARM = 4;

    typedef logic [CMD_W-1:0] cmd_t;

    // Counter only has to reach cycles-1, so clog2(cycles) bits suffice;
    // never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/light_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : light_debounce
//  Description : Two-flop synchronizer followed by a run-length debouncer.
//                The debounced level follows the synchronized level only
//                after it has differed for DEBOUNCE_CYCLES consecutive cycles.
//  Ports       : clk    - system clock
//                reset  - synchronous reset, active low
//                i_raw  - raw asynchronous level
//                o_db   - debounced level
//  Revision    : 1.0  initial release
// ============================================================================
module light_debounce
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_db
);

    localparam int                CNT_W      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;

    assign w_diff = r_sync ^ r_db;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                // Differing on this edge completes the run: accept the new
                // level. The counter therefore never goes past c_CNT_LAST.
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_db = r_db;

endmodule
`default_nettype wire

// File: rtl/light_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : light_input_conditioner
//  Description : Conditions cabin switches for the tail-light sequencer.
//                Each raw input is synchronized and debounced, then turn
//                signals are made mutually exclusive, brake/fog pass through
//                and the hazard button drives a toggle latch.
//  Ports       : clk                         - system clock
//                reset                       - synchronous reset, active low
//                sw_left/right/brake/fog     - raw level switches
//                btn_alarm                   - raw momentary hazard button
//                left/right/brake/fog/alarm  - registered clean commands
//                conflict                    - both turn switches asserted
//  Revision    : 1.0  initial release
// ============================================================================
module light_input_conditioner
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_left,
    input  logic sw_right,
    input  logic sw_brake,
    input  logic sw_fog,
    input  logic btn_alarm,
    output logic left,
    output logic right,
    output logic brake,
    output logic fog,
    output logic alarm,
    output logic conflict
);

    cmd_t w_raw;
    cmd_t w_db;
    logic w_alarm_rise;

    logic r_left;
    logic r_right;
    logic r_brake;
    logic r_fog;
    logic r_alarm;
    logic r_conflict;
    logic r_alarm_db_q;

    assign w_raw[LEFT]  = sw_left;
    assign w_raw[RIGHT] = sw_right;
    assign w_raw[BRAKE] = sw_brake;
    assign w_raw[FOG]   = sw_fog;
    assign w_raw[ALARM] = btn_alarm;

    generate
        for (genvar gi = 0; gi < CMD_W; gi++) begin : g_debounce
            light_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .i_raw (w_raw[gi]),
                .o_db  (w_db[gi])
            );
        end
    endgenerate

    // The alarm latch is the output register itself, so a debounced press
    // reaches the pin on the same edge as the other commands. The delayed
    // copy starts at 0, so a button held through reset counts as a press.
    assign w_alarm_rise = w_db[ALARM] & ~r_alarm_db_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_brake      <= 1'b0;
            r_fog        <= 1'b0;
            r_alarm      <= 1'b0;
            r_conflict   <= 1'b0;
            r_alarm_db_q <= 1'b0;
        end else begin
            r_left       <= w_db[LEFT]  & ~w_db[RIGHT];
            r_right      <= w_db[RIGHT] & ~w_db[LEFT];
            r_conflict   <= w_db[LEFT]  &  w_db[RIGHT];
            r_brake      <= w_db[BRAKE];
            r_fog        <= w_db[FOG];
            r_alarm      <= r_alarm ^ w_alarm_rise;
            r_alarm_db_q <= w_db[ALARM];
        end
    end

    assign left     = r_left;
    assign right    = r_right;
    assign brake    = r_brake;
    assign fog      = r_fog;
    assign alarm    = r_alarm;
    assign conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_light_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_input_conditioner
//  Description : Self-checking bench for light_input_conditioner with
//                DEBOUNCE_CYCLES = 4. A behavioural model keeps a history of
//                synchronized samples and accepts a new level once the last
//                DEBOUNCE_CYCLES samples all disagree with the current one.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_light_input_conditioner;
    import light_pkg::*;

    localparam int c_DB = 4;

    logic clk = 1'b0;
    logic reset;
    logic sw_left, sw_right, sw_brake, sw_fog, btn_alarm;
    logic left, right, brake, fog, alarm, conflict;

    int n_cmp = 0;
    int n_err = 0;

    light_input_conditioner #(
        .DEBOUNCE_CYCLES (c_DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_left   (sw_left),
        .sw_right  (sw_right),
        .sw_brake  (sw_brake),
        .sw_fog    (sw_fog),
        .btn_alarm (btn_alarm),
        .left      (left),
        .right     (right),
        .brake     (brake),
        .fog       (fog),
        .alarm     (alarm),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [4:0] m_s1, m_s2, m_db, m_db_prev;
    logic [4:0] m_hist[$];
    logic       m_left, m_right, m_brake, m_fog, m_alarm, m_conflict;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input logic [4:0] raw, input logic rst_n);
        bit all_diff;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_db_prev = '0;
            m_hist.delete();
            m_left = 0; m_right = 0; m_brake = 0; m_fog = 0;
            m_alarm = 0; m_conflict = 0;
        end else begin
            // outputs reflect debounced state before this edge
            m_left     = m_db[LEFT]  && !m_db[RIGHT];
            m_right    = m_db[RIGHT] && !m_db[LEFT];
            m_conflict = m_db[LEFT]  &&  m_db[RIGHT];
            m_brake    = m_db[BRAKE];
            m_fog      = m_db[FOG];
            if (m_db[ALARM] && !m_db_prev[ALARM]) m_alarm = !m_alarm;
            m_db_prev  = m_db;
            // debounce: last c_DB synchronized samples all disagree -> accept
            m_hist.push_back(m_s2);
            if (m_hist.size() > c_DB) void'(m_hist.pop_front());
            for (int b = 0; b < CMD_W; b++) begin
                all_diff = (m_hist.size() == c_DB);
                foreach (m_hist[k]) if (m_hist[k][b] == m_db[b]) all_diff = 0;
                if (all_diff) m_db[b] = !m_db[b];
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next
    // falling edge.
    task automatic tick(input logic [4:0] raw, input logic rst_n);
        sw_left   = raw[LEFT];
        sw_right  = raw[RIGHT];
        sw_brake  = raw[BRAKE];
        sw_fog    = raw[FOG];
        btn_alarm = raw[ALARM];
        reset     = rst_n;
        @(posedge clk);
        model_step(raw, rst_n);
        @(negedge clk);
        chk("left",     left,     m_left);
        chk("right",    right,    m_right);
        chk("conflict", conflict, m_conflict);
        chk("brake",    brake,    m_brake);
        chk("fog",      fog,      m_fog);
        chk("alarm",    alarm,    m_alarm);
    endtask

    task automatic run(input logic [4:0] raw, input logic rst_n, input int n);
        for (int i = 0; i < n; i++) tick(raw, rst_n);
    endtask

    function automatic logic [4:0] bitv(input int idx);
        logic [4:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [4:0] raw;
        logic       seen;
        logic       rst_n;

        reset = 0;
        sw_left = 0; sw_right = 0; sw_brake = 0; sw_fog = 0; btn_alarm = 0;
        model_step('0, 1'b0);
        @(negedge clk);

        // All raw inputs high through and after reset
        run(5'h1F, 1'b0, 2);
        chk("rst_alarm_zero", alarm, 1'b0);
        run(5'h1F, 1'b1, 6);
        chk("all_conflict_pre", conflict, 1'b0);
        run(5'h1F, 1'b1, 1);
        chk("all_conflict_7", conflict, 1'b1);
        chk("all_alarm_7",    alarm,    1'b1);
        chk("all_brake_7",    brake,    1'b1);
        chk("all_left_7",     left,     1'b0);

        // Left held: rises exactly 7 edges after the change
        run('0, 1'b0, 2);
        run(bitv(LEFT), 1'b1, 6);
        chk("left_pre7", left, 1'b0);
        run(bitv(LEFT), 1'b1, 1);
        chk("left_at7", left, 1'b1);

        // Left glitches every 3 cycles never reach the output
        run('0, 1'b0, 2);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick((i % 3 == 0) ? bitv(LEFT) : 5'h00, 1'b1);
            seen |= left;
        end
        chk("glitch_left_seen", seen, 1'b0);

        // Left held then right joins, then right leaves
        run(bitv(LEFT), 1'b1, 10);
        run(bitv(LEFT) | bitv(RIGHT), 1'b1, 7);
        chk("lr_conflict", conflict, 1'b1);
        chk("lr_left",     left,     1'b0);
        run(bitv(LEFT), 1'b1, 7);
        chk("l_back_left", left, 1'b1);

        // Alarm press / hold / release / press
        run('0, 1'b0, 2);
        run(bitv(ALARM), 1'b1, 6);
        chk("alarm_pre7", alarm, 1'b0);
        run(bitv(ALARM), 1'b1, 14);
        chk("alarm_held", alarm, 1'b1);
        run('0, 1'b1, 20);
        chk("alarm_released", alarm, 1'b1);
        run(bitv(ALARM), 1'b1, 7);
        chk("alarm_second", alarm, 1'b0);

        // Short brake pulse; fog with reset mid-debounce
        run('0, 1'b0, 2);
        run(bitv(BRAKE), 1'b1, 3);
        run('0, 1'b1, 10);
        run(bitv(FOG), 1'b1, 5);
        run(bitv(FOG), 1'b0, 1);
        run(bitv(FOG), 1'b1, 6);
        chk("fog_after_rst_pre", fog, 1'b0);
        run(bitv(FOG), 1'b1, 1);
        chk("fog_after_rst_7", fog, 1'b1);

        // Randomized phase with slow toggling, glitches and rare resets
        raw = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < CMD_W; b++)
                if ($urandom_range(0, 5) == 0) raw[b] = !raw[b];
            rst_n = ($urandom_range(0, 299) != 0);
            tick(raw, rst_n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
